// File: rtl/spi_frame_bridge_pkg.sv
// Shared types and constants for the SPI frame bridge.
package spi_bridge_pkg;

   // Encodings are visible on state_dbg, so keep them explicit.
   typedef enum logic [4:0] {
      IDLE    = 5'd0,
      CMD     = 5'd1,
      W_LEN   = 5'd2,
      W_HDR   = 5'd3,
      W_BYTE  = 5'd4,
      W_WORD  = 5'd5,
      W_PAD   = 5'd6,
      R_HDR   = 5'd7,
      R_LEN   = 5'd8,
      R_BYTE  = 5'd9,
      R_FETCH = 5'd10,
      STAT    = 5'd11
   } state_t;

   localparam logic [7:0] OPC_TX   = 8'h66;
   localparam logic [7:0] OPC_RX   = 8'h77;
   localparam logic [7:0] OPC_STAT = 8'h55;

endpackage

// File: rtl/spi_frame_bridge_if.sv
// SPI byte stream and FIFO request bus shared by the bridge and its neighbours.
interface spi_frame_bridge_if #(
   parameter int DW = 16,
   parameter int CW = 11
);
   logic          rx_valid;
   logic [7:0]    rx_data;
   logic          rx_pop;
   logic          tx_ready;
   logic          tx_push;
   logic [7:0]    tx_data;
   logic          fifo_wr;
   logic [DW-1:0] fifo_wdata;
   logic          fifo_rd;
   logic [DW-1:0] fifo_rdata;
   logic          fifo_ack;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;

   // Bridge side.
   modport master (
      input  rx_valid, rx_data, tx_ready, fifo_rdata, fifo_ack,
             fifo_full, fifo_empty, fifo_count,
      output rx_pop, tx_push, tx_data, fifo_wr, fifo_wdata, fifo_rd
   );

   // SPI core / FIFO side.
   modport slave (
      output rx_valid, rx_data, tx_ready, fifo_rdata, fifo_ack,
             fifo_full, fifo_empty, fifo_count,
      input  rx_pop, tx_push, tx_data, fifo_wr, fifo_wdata, fifo_rd
   );
endinterface

// File: rtl/spi_frame_bridge_irq_stretch.sv
// Stretches frame_done rising edges into IRQ_CYCLES-long pulses, queueing
// up to 15 edges that arrive while a pulse is active.
module irq_stretch #(
   parameter int IRQ_CYCLES = 50
) (
   input  logic clk,
   input  logic rst_n,
   input  logic frame_done_i,
   output logic irq_o
);
   localparam int CNTW = (IRQ_CYCLES > 1) ? $clog2(IRQ_CYCLES) : 1;

   logic            fd_q;
   logic            irq_q, irq_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic [3:0]      pend_q, pend_d;
   logic            rise;

   assign rise  = frame_done_i & ~fd_q;
   assign irq_o = irq_q;

   // Pulse timing; a pulse ending always leaves one low cycle before the next.
   always_comb begin
      irq_d  = irq_q;
      cnt_d  = cnt_q;
      pend_d = pend_q;
      if (irq_q) begin
         if (rise && (pend_q != 4'hF)) pend_d = pend_q + 4'd1;
         if (cnt_q == '0) irq_d = 1'b0;
         else             cnt_d = cnt_q - CNTW'(1);
      end else if (pend_q != 4'd0) begin
         irq_d  = 1'b1;
         cnt_d  = CNTW'(IRQ_CYCLES - 1);
         pend_d = rise ? pend_q : (pend_q - 4'd1);
      end else if (rise) begin
         irq_d = 1'b1;
         cnt_d = CNTW'(IRQ_CYCLES - 1);
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fd_q   <= 1'b0;
         irq_q  <= 1'b0;
         cnt_q  <= '0;
         pend_q <= '0;
      end else begin
         fd_q   <= frame_done_i;
         irq_q  <= irq_d;
         cnt_q  <= cnt_d;
         pend_q <= pend_d;
      end
   end
endmodule

// File: rtl/spi_frame_bridge.sv
// SPI-to-FIFO frame bridge: 0x66 write frames into the FIFO, 0x77 read
// frames out of it. Optional macro SPI_BRIDGE_STATUS_EN adds the 0x55
// FIFO-count status opcode.
module spi_frame_bridge
   import spi_bridge_pkg::*;
#(
   parameter int DW             = 16,
   parameter int CW             = 11,
   parameter int IRQ_CYCLES     = 50,
   parameter int TIMEOUT_CYCLES = 5000
) (
   input  logic                      clk,
   input  logic                      rst_n,
   spi_frame_bridge_if.master        bus,
   input  logic                      frame_done,
   output logic                      cpu_irq,
   output logic                      err_timeout,
   output logic [4:0]                state_dbg
);
   localparam int BPW = DW / 8;
   localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

   state_t        state_q, state_d;
   logic          en_q;
   logic [7:0]    byte_q, byte_d;
   logic [7:0]    len_q, len_d;
   logic [7:0]    cnt_q, cnt_d;
   logic [3:0]    idx_q, idx_d;
   logic [DW-1:0] word_q, word_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic          pad_q, pad_d;
   logic          rx_pop_q, rx_pop_d;
   logic          tx_push_q, tx_push_d;
   logic [7:0]    tx_data_q, tx_data_d;
   logic          wr_q, wr_d;
   logic          rd_q, rd_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic          err_q, err_d;
   logic          rx_take, tx_go;
   logic          word_end, len_end;

`ifdef SPI_BRIDGE_STATUS_EN
   logic [10:0]   cnt11;
   assign cnt11 = 11'(bus.fifo_count);
`endif

   // Strobes are registered, so the cycle after a strobe still shows the old
   // rx_valid/tx_ready; gating on the strobe avoids a double transfer.
   assign rx_take  = bus.rx_valid && !rx_pop_q;
   assign tx_go    = bus.tx_ready && !tx_push_q;
   assign word_end = (idx_q + 4'd1) == 4'(BPW);
   assign len_end  = (cnt_q + 8'd1) == len_q;

   // Frame sequencing.
   always_comb begin
      state_d   = state_q;
      byte_d    = byte_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      word_d    = word_q;
      tmr_d     = tmr_q;
      pad_d     = pad_q;
      rx_pop_d  = 1'b0;
      tx_push_d = 1'b0;
      tx_data_d = tx_data_q;
      wr_d      = wr_q;
      rd_d      = rd_q;
      wdata_d   = wdata_q;
      err_d     = 1'b0;
      if (en_q) begin
         case (state_q)
            IDLE: if (rx_take) begin
               rx_pop_d = 1'b1;
               byte_d   = bus.rx_data;
               state_d  = CMD;
            end
            CMD: begin
               case (byte_q)
                  OPC_TX:   state_d = W_LEN;
                  OPC_RX:   state_d = R_HDR;
`ifdef SPI_BRIDGE_STATUS_EN
                  OPC_STAT: begin
                     idx_d   = 4'd0;
                     state_d = STAT;
                  end
`endif
                  default:  state_d = IDLE;
               endcase
            end
            W_LEN: if (rx_take) begin
               rx_pop_d = 1'b1;
               len_d    = bus.rx_data;
               cnt_d    = 8'd0;
               idx_d    = 4'd0;
               word_d   = '0;
               pad_d    = 1'b0;
               tmr_d    = '0;
               state_d  = (bus.rx_data == 8'd0) ? IDLE : W_HDR;
            end
            W_HDR: begin
               if (wr_q) begin
                  if (bus.fifo_ack) begin
                     wr_d    = 1'b0;
                     tmr_d   = '0;
                     state_d = W_BYTE;
                  end
               end else if (!bus.fifo_full) begin
                  wr_d                = 1'b1;
                  wdata_d             = '0;
                  wdata_d[DW-1 -: 16] = {OPC_TX, len_q};
               end
            end
            W_BYTE: begin
               if (rx_take) begin
                  rx_pop_d = 1'b1;
                  word_d   = word_q | ({{(DW-8){1'b0}}, bus.rx_data}
                                       << (8 * (BPW - 1 - int'(idx_q))));
                  cnt_d    = cnt_q + 8'd1;
                  idx_d    = idx_q + 4'd1;
                  tmr_d    = '0;
                  if (word_end || len_end) state_d = W_WORD;
               end else if (bus.rx_valid) begin
                  tmr_d = '0;
               end else if (tmr_q == TW'(TIMEOUT_CYCLES - 1)) begin
                  err_d   = 1'b1;
                  pad_d   = 1'b1;
                  state_d = W_PAD;
               end else begin
                  tmr_d = tmr_q + TW'(1);
               end
            end
            // Low bytes of word_q are already zero, so padding only advances counters.
            W_PAD: begin
               cnt_d = cnt_q + 8'd1;
               idx_d = idx_q + 4'd1;
               if (word_end || len_end) state_d = W_WORD;
            end
            W_WORD: begin
               if (wr_q) begin
                  if (bus.fifo_ack) begin
                     wr_d   = 1'b0;
                     word_d = '0;
                     idx_d  = 4'd0;
                     tmr_d  = '0;
                     if (cnt_q == len_q) state_d = IDLE;
                     else                state_d = pad_q ? W_PAD : W_BYTE;
                  end
               end else if (!bus.fifo_full) begin
                  wr_d    = 1'b1;
                  wdata_d = word_q;
               end
            end
            R_HDR: begin
               if (rd_q) begin
                  if (bus.fifo_ack) begin
                     rd_d    = 1'b0;
                     len_d   = bus.fifo_rdata[DW-9 -: 8];
                     state_d = R_LEN;
                  end
               end else if (bus.fifo_empty) begin
                  if (tx_go) begin
                     tx_push_d = 1'b1;
                     tx_data_d = 8'h00;
                     state_d   = IDLE;
                  end
               end else begin
                  rd_d = 1'b1;
               end
            end
            R_LEN: if (tx_go) begin
               tx_push_d = 1'b1;
               tx_data_d = len_q;
               cnt_d     = 8'd0;
               idx_d     = 4'd0;
               state_d   = (len_q == 8'd0) ? IDLE : R_FETCH;
            end
            R_FETCH: begin
               if (rd_q) begin
                  if (bus.fifo_ack) begin
                     rd_d    = 1'b0;
                     word_d  = bus.fifo_rdata;
                     idx_d   = 4'd0;
                     state_d = R_BYTE;
                  end
               end else if (!bus.fifo_empty) begin
                  rd_d = 1'b1;
               end
            end
            R_BYTE: if (tx_go) begin
               tx_push_d = 1'b1;
               tx_data_d = word_q[DW-1 -: 8];
               word_d    = word_q << 8;
               cnt_d     = cnt_q + 8'd1;
               idx_d     = idx_q + 4'd1;
               if (len_end)       state_d = IDLE;
               else if (word_end) state_d = R_FETCH;
            end
`ifdef SPI_BRIDGE_STATUS_EN
            STAT: if (tx_go) begin
               tx_push_d = 1'b1;
               tx_data_d = (idx_q == 4'd0) ? {5'b0, cnt11[10:8]} : cnt11[7:0];
               idx_d     = idx_q + 4'd1;
               if (idx_q == 4'd1) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
         endcase
      end
   end

   // State registers; en_q holds the FSM off for the first edge after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         en_q      <= 1'b0;
         byte_q    <= '0;
         len_q     <= '0;
         cnt_q     <= '0;
         idx_q     <= '0;
         word_q    <= '0;
         tmr_q     <= '0;
         pad_q     <= 1'b0;
         rx_pop_q  <= 1'b0;
         tx_push_q <= 1'b0;
         tx_data_q <= '0;
         wr_q      <= 1'b0;
         rd_q      <= 1'b0;
         wdata_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         en_q      <= 1'b1;
         byte_q    <= byte_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         word_q    <= word_d;
         tmr_q     <= tmr_d;
         pad_q     <= pad_d;
         rx_pop_q  <= rx_pop_d;
         tx_push_q <= tx_push_d;
         tx_data_q <= tx_data_d;
         wr_q      <= wr_d;
         rd_q      <= rd_d;
         wdata_q   <= wdata_d;
         err_q     <= err_d;
      end
   end

   assign bus.rx_pop     = rx_pop_q;
   assign bus.tx_push    = tx_push_q;
   assign bus.tx_data    = tx_data_q;
   assign bus.fifo_wr    = wr_q;
   assign bus.fifo_rd    = rd_q;
   assign bus.fifo_wdata = wdata_q;
   assign err_timeout    = err_q;
   assign state_dbg      = state_q;

   irq_stretch #(.IRQ_CYCLES(IRQ_CYCLES)) u_irq (
      .clk          (clk),
      .rst_n        (rst_n),
      .frame_done_i (frame_done),
      .irq_o        (cpu_irq)
   );
endmodule

// File: tb/tb_spi_frame_bridge.sv
// Directed bench for spi_frame_bridge: one DW=16 and one DW=32 instance,
// each with a byte-queue SPI model and a queue-backed FIFO model.
module tb_spi_frame_bridge;
   import spi_bridge_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       fd16 = 1'b0, fd32 = 1'b0;
   logic       irq16, irq32, err16, err32;
   logic [4:0] st16, st32;

   int checks = 0;
   int failures = 0;

   spi_frame_bridge_if #(.DW(16), .CW(11)) b16();
   spi_frame_bridge_if #(.DW(32), .CW(11)) b32();

   spi_frame_bridge #(.DW(16), .CW(11), .IRQ_CYCLES(50), .TIMEOUT_CYCLES(100)) dut16 (
      .clk(clk), .rst_n(rst_n), .bus(b16), .frame_done(fd16),
      .cpu_irq(irq16), .err_timeout(err16), .state_dbg(st16));

   spi_frame_bridge #(.DW(32), .CW(11), .IRQ_CYCLES(50), .TIMEOUT_CYCLES(5000)) dut32 (
      .clk(clk), .rst_n(rst_n), .bus(b32), .frame_done(fd32),
      .cpu_irq(irq32), .err_timeout(err32), .state_dbg(st32));

   logic [7:0]  rxq16[$], txl16[$], rxq32[$], txl32[$];
   logic [15:0] mem16[$];
   logic [31:0] mem32[$];
   logic        ovr16_en = 1'b0;
   logic [10:0] ovr16 = '0;

   // DW=16 side: SPI core and FIFO with one-cycle ack latency.
   initial begin
      logic ack_n;
      b16.rx_valid = 1'b0; b16.rx_data = '0; b16.tx_ready = 1'b1;
      b16.fifo_ack = 1'b0; b16.fifo_rdata = '0; b16.fifo_full = 1'b0;
      b16.fifo_empty = 1'b1; b16.fifo_count = '0;
      forever begin
         @(posedge clk);
         if (b16.rx_pop && rxq16.size() > 0) void'(rxq16.pop_front());
         if (b16.tx_push) txl16.push_back(b16.tx_data);
         if (b16.fifo_wr && b16.fifo_ack) mem16.push_back(b16.fifo_wdata);
         if (b16.fifo_rd && b16.fifo_ack && mem16.size() > 0) void'(mem16.pop_front());
         ack_n = (b16.fifo_wr || b16.fifo_rd) && !b16.fifo_ack;
         #1;
         b16.fifo_ack   = ack_n;
         b16.fifo_rdata = (mem16.size() > 0) ? mem16[0] : '0;
         b16.rx_valid   = rxq16.size() > 0;
         b16.rx_data    = (rxq16.size() > 0) ? rxq16[0] : '0;
         b16.fifo_empty = mem16.size() == 0;
         b16.fifo_count = ovr16_en ? ovr16 : 11'(mem16.size());
      end
   end

   // DW=32 side.
   initial begin
      logic ack_n;
      b32.rx_valid = 1'b0; b32.rx_data = '0; b32.tx_ready = 1'b1;
      b32.fifo_ack = 1'b0; b32.fifo_rdata = '0; b32.fifo_full = 1'b0;
      b32.fifo_empty = 1'b1; b32.fifo_count = '0;
      forever begin
         @(posedge clk);
         if (b32.rx_pop && rxq32.size() > 0) void'(rxq32.pop_front());
         if (b32.tx_push) txl32.push_back(b32.tx_data);
         if (b32.fifo_wr && b32.fifo_ack) mem32.push_back(b32.fifo_wdata);
         if (b32.fifo_rd && b32.fifo_ack && mem32.size() > 0) void'(mem32.pop_front());
         ack_n = (b32.fifo_wr || b32.fifo_rd) && !b32.fifo_ack;
         #1;
         b32.fifo_ack   = ack_n;
         b32.fifo_rdata = (mem32.size() > 0) ? mem32[0] : '0;
         b32.rx_valid   = rxq32.size() > 0;
         b32.rx_data    = (rxq32.size() > 0) ? rxq32[0] : '0;
         b32.fifo_empty = mem32.size() == 0;
         b32.fifo_count = 11'(mem32.size());
      end
   end

   // Waits until both bridges are idle with nothing queued; ok=0 on expiry.
   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 800; i++) begin
         @(posedge clk); #1;
         if (rxq16.size() == 0 && rxq32.size() == 0 && st16 == 5'd0 && st32 == 5'd0 &&
             !b16.fifo_wr && !b16.fifo_rd && !b32.fifo_wr && !b32.fifo_rd) begin
            ok = 1'b1;
            break;
         end
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bit ok;
      rst_n = 1'b0;
      rxq16.push_back(8'h01);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({st16, b16.rx_pop, b16.tx_push, b16.fifo_wr, b16.fifo_rd, irq16, err16} !== 11'd0) begin
         failures++; $display("FAIL reset16_ctl: got %b want 0", {st16, b16.rx_pop, b16.tx_push, b16.fifo_wr, b16.fifo_rd, irq16, err16});
      end
      checks++;
      if ({st32, b32.rx_pop, b32.tx_push, b32.fifo_wr, b32.fifo_rd, irq32, err32} !== 11'd0) begin
         failures++; $display("FAIL reset32_ctl: got %b want 0", {st32, b32.rx_pop, b32.tx_push, b32.fifo_wr, b32.fifo_rd, irq32, err32});
      end
      checks++;
      if ({b16.tx_data, b16.fifo_wdata, b32.fifo_wdata} !== 56'd0) begin
         failures++; $display("FAIL reset_data: got %h want 0", {b16.tx_data, b16.fifo_wdata, b32.fifo_wdata});
      end
      rst_n = 1'b1;
      // First edge after release only arms the FSM; the pending byte is popped on the second.
      @(posedge clk); #1;
      checks++;
      if ({b16.rx_pop, st16} !== 6'd0) begin
         failures++; $display("FAIL first_edge: got pop/state %b want 0", {b16.rx_pop, st16});
      end
      @(posedge clk); #1;
      checks++;
      if ({b16.rx_pop, st16} !== {1'b1, 5'd1}) begin
         failures++; $display("FAIL second_edge: got pop/state %b want 1_00001", {b16.rx_pop, st16});
      end
      wait_idle(ok);
      checks++;
      if (ok !== 1'b1) begin failures++; $display("FAIL reset_idle: got %0b want 1", ok); end
   endtask

   task automatic test_write16();
      bit ok;
      mem16.delete();
      rxq16 = '{8'h66, 8'h03, 8'hA1, 8'hB2, 8'hC3};
      wait_idle(ok);
      checks++;
      if (ok !== 1'b1 || mem16.size() != 3) begin
         failures++; $display("FAIL write16_words: got %0d words ok=%0b want 3", mem16.size(), ok);
      end else begin
         checks++;
         if ({mem16[0], mem16[1], mem16[2]} !== 48'h6603_A1B2_C300) begin
            failures++; $display("FAIL write16_data: got %h want 6603a1b2c300", {mem16[0], mem16[1], mem16[2]});
         end
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      txl16.delete();
      rxq16.push_back(8'h77);
      wait_idle(ok);
      checks++;
      if (ok !== 1'b1 || txl16.size() != 4 || mem16.size() != 0) begin
         failures++; $display("FAIL readback16_len: got %0d tx %0d left ok=%0b want 4 0", txl16.size(), mem16.size(), ok);
      end else begin
         checks++;
         if ({txl16[0], txl16[1], txl16[2], txl16[3]} !== 32'h03A1_B2C3) begin
            failures++; $display("FAIL readback16_data: got %h want 03a1b2c3", {txl16[0], txl16[1], txl16[2], txl16[3]});
         end
      end
   endtask

   task automatic test_len_zero();
      bit ok;
      mem16.delete();
      rxq16 = '{8'h66, 8'h00, 8'h12};
      wait_idle(ok);
      checks++;
      if (ok !== 1'b1 || mem16.size() != 0) begin
         failures++; $display("FAIL len_zero: got %0d words ok=%0b want 0", mem16.size(), ok);
      end
   endtask

   task automatic test_timeout();
      int cyc = 0, last_pop = 0, err_cyc = -1, n_err = 0;
      logic [4:0] st_err = '0;
      mem16.delete();
      rxq16 = '{8'h66, 8'h04, 8'hAA};
      for (int i = 0; i < 300; i++) begin
         @(posedge clk); #1;
         cyc++;
         if (b16.rx_pop) last_pop = cyc;
         if (err16) begin
            n_err++;
            if (err_cyc < 0) begin err_cyc = cyc; st_err = st16; end
         end
      end
      checks++;
      if (n_err != 1) begin failures++; $display("FAIL timeout_pulses: got %0d want 1", n_err); end
      // Pop cycle, then 100 low cycles, then the pulse.
      checks++;
      if (err_cyc - last_pop != 101) begin
         failures++; $display("FAIL timeout_delay: got %0d want 101", err_cyc - last_pop);
      end
      checks++;
      if (st_err !== 5'd6) begin failures++; $display("FAIL timeout_state: got %0d want 6", st_err); end
      checks++;
      if (mem16.size() != 3 || st16 !== 5'd0) begin
         failures++; $display("FAIL timeout_words: got %0d words state %0d want 3 0", mem16.size(), st16);
      end else begin
         checks++;
         if ({mem16[0], mem16[1], mem16[2]} !== 48'h6604_AA00_0000) begin
            failures++; $display("FAIL timeout_data: got %h want 6604aa000000", {mem16[0], mem16[1], mem16[2]});
         end
      end
   endtask

   task automatic test_read32();
      bit ok;
      txl32.delete();
      mem32 = '{32'h6605_0000, 32'h1122_3344, 32'h5500_0000};
      rxq32.push_back(8'h77);
      wait_idle(ok);
      checks++;
      if (ok !== 1'b1 || txl32.size() != 6 || mem32.size() != 0) begin
         failures++; $display("FAIL read32_len: got %0d tx %0d left ok=%0b want 6 0", txl32.size(), mem32.size(), ok);
      end else begin
         checks++;
         if ({txl32[0], txl32[1], txl32[2], txl32[3], txl32[4], txl32[5]} !== 48'h05_1122_3344_55) begin
            failures++; $display("FAIL read32_data: got %h want 051122334455", {txl32[0], txl32[1], txl32[2], txl32[3], txl32[4], txl32[5]});
         end
      end
   endtask

   task automatic test_read_empty();
      int rd_seen = 0;
      mem16.delete();
      txl16.delete();
      rxq16.push_back(8'h77);
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (b16.fifo_rd) rd_seen++;
      end
      checks++;
      if (rd_seen != 0) begin failures++; $display("FAIL empty_rd: got %0d rd cycles want 0", rd_seen); end
      checks++;
      if (txl16.size() != 1 || st16 !== 5'd0) begin
         failures++; $display("FAIL empty_tx_count: got %0d bytes state %0d want 1 0", txl16.size(), st16);
      end else begin
         checks++;
         if (txl16[0] !== 8'h00) begin failures++; $display("FAIL empty_tx_byte: got %h want 00", txl16[0]); end
      end
   endtask

   task automatic test_unknown();
      bit ok;
      txl32.delete();
      mem32.delete();
      rxq32.push_back(8'h12);
      wait_idle(ok);
      checks++;
      if (ok !== 1'b1 || txl32.size() != 0 || mem32.size() != 0) begin
         failures++; $display("FAIL unknown_opc: got tx %0d words %0d ok=%0b want 0 0", txl32.size(), mem32.size(), ok);
      end
   endtask

   task automatic test_stat();
      bit ok;
      txl16.delete();
      ovr16_en = 1'b1;
      ovr16 = 11'h123;
      rxq16.push_back(8'h55);
      wait_idle(ok);
      ovr16_en = 1'b0;
`ifdef SPI_BRIDGE_STATUS_EN
      checks++;
      if (ok !== 1'b1 || txl16.size() != 2) begin
         failures++; $display("FAIL stat_count: got %0d bytes ok=%0b want 2", txl16.size(), ok);
      end else begin
         checks++;
         if ({txl16[0], txl16[1]} !== 16'h0123) begin
            failures++; $display("FAIL stat_data: got %h want 0123", {txl16[0], txl16[1]});
         end
      end
`else
      checks++;
      if (ok !== 1'b1 || txl16.size() != 0) begin
         failures++; $display("FAIL stat_disabled: got %0d bytes ok=%0b want 0", txl16.size(), ok);
      end
`endif
   endtask

   task automatic test_irq();
      logic exp;
      @(posedge clk); #1;
      fd16 = 1'b1;
      for (int k = 1; k <= 110; k++) begin
         @(posedge clk); #1;
         exp = ((k >= 1) && (k <= 50)) || ((k >= 52) && (k <= 101));
         checks++;
         if (irq16 !== exp) begin
            failures++; $display("FAIL irq_cycle_%0d: got %b want %b", k, irq16, exp);
         end
         fd16 = (k == 10);
      end
   endtask

   task automatic test_irq_saturate();
      int pulses = 0;
      logic prev = 1'b0;
      // 17 edges during the first pulse: 1 immediate + 15 pending (saturated).
      for (int i = 0; i < 1100; i++) begin
         @(posedge clk); #1;
         if (irq32 && !prev) pulses++;
         prev = irq32;
         fd32 = (i < 34) ? ((i % 2) == 0) : 1'b0;
      end
      checks++;
      if (pulses != 16) begin failures++; $display("FAIL irq_saturate: got %0d pulses want 16", pulses); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_write16();
      test_back_to_back();
      test_len_zero();
      test_timeout();
      test_read32();
      test_read_empty();
      test_unknown();
      test_stat();
      test_irq();
      test_irq_saturate();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/spi_frame_bridge.md
SPI_FRAME_BRIDGE -- requirements
Module: spi_frame_bridge

Interface
REQ-001 Parameter DW, default 16, FIFO word width in bits; SHALL be a multiple of 8 in the range 16..64; BPW = DW/8 bytes per word.
REQ-002 Parameter CW, default 11, FIFO count width.
REQ-003 Parameter IRQ_CYCLES, default 50, cpu_irq pulse length in clk cycles.
REQ-004 Parameter TIMEOUT_CYCLES, default 5000, maximum clk cycles allowed between SPI bytes inside a write frame.
REQ-005 Ports: clk in 1, the single clock; rst_n in 1, reset, asynchronous and active-low.
REQ-006 rx_valid in 1, a byte is available from the SPI slave core; rx_data in 8, that byte; rx_pop out 1, one-cycle consume strobe.
REQ-007 tx_ready in 1, the SPI core can accept a byte; tx_push out 1, one-cycle load strobe; tx_data out 8, the byte to load.
REQ-008 fifo_wr out 1, write request; fifo_wdata out DW, write word; fifo_rd out 1, read request; fifo_rdata in DW, read word; fifo_ack in 1, request completion strobe.
REQ-009 fifo_full in 1; fifo_empty in 1; fifo_count in CW.
REQ-010 frame_done in 1, radio-side frame-received event; cpu_irq out 1, interrupt to the CPU.
REQ-011 err_timeout out 1, one-cycle pulse on a write-frame timeout; state_dbg out 5, the current state encoding.

Function
REQ-012 FSM states: IDLE, CMD, W_LEN, W_HDR, W_BYTE, W_WORD, W_PAD, R_HDR, R_LEN, R_BYTE, R_FETCH, STAT.
REQ-013 IDLE: when rx_valid is high, the FSM SHALL pulse rx_pop and go to CMD; the next cycle it SHALL decode the byte as follows.
REQ-014 Opcodes: 0x66 goes to W_LEN; 0x77 goes to R_HDR; 0x55 goes to STAT (macro only, see REQ-027); any other byte is discarded and the FSM returns to IDLE.
REQ-015 W_LEN: the popped byte SHALL be stored as LEN; LEN of 0 SHALL return the FSM to IDLE with no FIFO write.
REQ-016 W_HDR: the FSM SHALL write the header word {0x66, LEN, zeros} once fifo_full is low.
REQ-017 FIFO handshake: fifo_wr/fifo_rd SHALL be raised only when full/empty is low, held until fifo_ack, and dropped on the cycle after fifo_ack; each request SHALL complete exactly one transfer.
REQ-018 W_BYTE: data bytes SHALL be packed MSB-first into a word; the FSM SHALL write the word in W_WORD after BPW bytes, or after the LEN-th byte with the unused low bytes set to zero.
REQ-019 Data words per write frame SHALL be ceil(LEN/BPW); the byte counter SHALL be 8 bits and SHALL NOT wrap past LEN.
REQ-020 Timeout: if rx_valid stays low for TIMEOUT_CYCLES in W_BYTE, the FSM SHALL pulse err_timeout and enter W_PAD, which writes zero bytes until LEN bytes are complete. This keeps FIFO framing consistent; the FSM then returns to IDLE.
REQ-021 R_HDR: if fifo_empty is high, the FSM SHALL push a 0x00 length byte and return to IDLE; otherwise it SHALL pop the header and push LEN = header[DW-9:DW-16].
REQ-022 Read frames SHALL push exactly LEN bytes, MSB-first per word, fetching a new word in R_FETCH after every BPW bytes; trailing pad bytes SHALL be dropped; tx_push only when tx_ready is high.
REQ-023 IRQ: on a rising edge of frame_done, cpu_irq SHALL go high for IRQ_CYCLES cycles. Edges arriving during a pulse SHALL increment a 4-bit pending counter that saturates at 15. Each pending event SHALL produce a further pulse after one low cycle.
REQ-024 The IRQ logic SHALL run independently of and concurrently with the main FSM.

Reset
REQ-025 While rst_n is low, the FSM SHALL be in IDLE, every output and counter SHALL be zero, and the pending count SHALL be zero; reset mid-frame SHALL abandon the frame without FIFO recovery.
REQ-026 The first FSM action SHALL occur no earlier than the second rising clk edge after rst_n deasserts.

Configuration
REQ-027 SPI_BRIDGE_STATUS_EN defined: opcode 0x55 enters STAT, which pushes two bytes, {5'b0, fifo_count[10:8]} then fifo_count[7:0], zero-extended or truncated to 11 bits, and returns to IDLE. Not defined: 0x55 is discarded like any unknown opcode, and STAT logic is absent.

Structure
REQ-028 Shared package spi_bridge_pkg SHALL hold the state enum and the constants OPC_TX=0x66, OPC_RX=0x77, OPC_STAT=0x55.
REQ-029 The IRQ pulse stretcher and pending counter SHALL be the sub-module irq_stretch, with parameter IRQ_CYCLES.

Verification
REQ-030 DW=16: send 0x66,0x03,0xA1,0xB2,0xC3 -> FIFO words 0x6603, 0xA1B2, 0xC300.
REQ-031 DW=32, FIFO preloaded {0x66050000, 0x11223344, 0x55000000}; send 0x77 -> tx bytes 0x05,0x11,0x22,0x33,0x44,0x55.
REQ-032 0x77 with FIFO empty -> single tx byte 0x00; no fifo_rd.
REQ-033 DW=16, TIMEOUT_CYCLES=100: send 0x66,0x04,0xAA, then stall 100 cycles -> err_timeout pulse; words 0x6604, 0xAA00, 0x0000; IDLE.
REQ-034 IRQ_CYCLES=50: frame_done edges at t=0 and t=10 -> cpu_irq high cycles 1-50, low at 51, high 52-101.
REQ-035 With macro, fifo_count=0x123: send 0x55 -> tx 0x01, 0x23; without macro -> no tx_push.
